// File: rtl/i2c_reg16_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg16_slave
//  Description : I2C target with 16-bit register sub-address and 8-bit data.
//                Decodes START / STOP / repeated START, ACKs SLAVE_ADDR and
//                issues one write strobe per data byte with address
//                auto-increment. Build macro I2C_SLAVE_RD_EN adds the read
//                path. Without it, reads are NACKed.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_reg16_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h30,
    parameter int         FILT_LEN   = 3       // legal range 1..7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_scl_in,
    input  logic        i2c_sda_in,
    output logic        i2c_sda_oe,
    output logic        reg_wr_en,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wr_data,
    input  logic [7:0]  reg_rd_data,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV       = 4'd1,
        ACK_DEV   = 4'd2,
        AH        = 4'd3,
        ACK_AH    = 4'd4,
        AL        = 4'd5,
        ACK_AL    = 4'd6,
        WR        = 4'd7,
        ACK_WR    = 4'd8,
        RD_LOAD   = 4'd9,
        RD        = 4'd10,
        RD_MACK   = 4'd11,
        WAIT_STOP = 4'd12
    } state_t;

    // Bit 0 carries SCL and bit 1 carries SDA through the conditioning chain.
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    logic [1:0] filt_q;
    logic [2:0] fcnt [2];

    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  shreg;
    logic [7:0]  addr_hi;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_bit;
    logic addr_match;
    logic dev_ack;

    // Synchronise both pins, then require FILT_LEN consecutive samples
    // that disagree with the filtered level before it is allowed to flip.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            fcnt[0] <= 3'd0;
            fcnt[1] <= 3'd0;
        end else begin
            sync1  <= {i2c_sda_in, i2c_scl_in};
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= 3'd0;
                end else if (fcnt[i] == 3'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= 3'd0;
                end else begin
                    fcnt[i] <= fcnt[i] + 3'd1;
                end
            end
        end
    end

    assign sda_bit   = filt[1];
    assign scl_rise  =  filt[0] & ~filt_q[0];
    assign scl_fall  = ~filt[0] &  filt_q[0];
    assign start_det =  filt[0] & filt_q[0] &  filt_q[1] & ~filt[1];
    assign stop_det  =  filt[0] & filt_q[0] & ~filt_q[1] &  filt[1];

    // General call (address 0) is never acknowledged.
    assign addr_match = (shreg[7:1] == SLAVE_ADDR) && (shreg[7:1] != 7'h00);

`ifdef I2C_SLAVE_RD_EN
    assign dev_ack = addr_match;
`else
    assign dev_ack = addr_match & ~shreg[0];
    logic unused_rd_data;
    assign unused_rd_data = ^reg_rd_data;
`endif

    // Protocol state machine: byte shifting, ACK drive, register strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            shreg       <= 8'h00;
            addr_hi     <= 8'h00;
            i2c_sda_oe  <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_addr    <= 16'h0000;
            reg_wr_data <= 8'h00;
            busy        <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            if (start_det) begin
                // Repeated START keeps the register pointer.
                state      <= DEV;
                cnt        <= 4'd0;
                i2c_sda_oe <= 1'b0;
                busy       <= 1'b1;
            end else if (stop_det) begin
                state      <= IDLE;
                cnt        <= 4'd0;
                i2c_sda_oe <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        i2c_sda_oe <= 1'b0;
                    end
                    DEV, AH, AL, WR: begin
                        if (scl_rise && (cnt != 4'd8)) begin
                            shreg <= {shreg[6:0], sda_bit};
                            cnt   <= cnt + 4'd1;
                            if ((state == WR) && (cnt == 4'd7)) begin
                                reg_wr_data <= {shreg[6:0], sda_bit};
                                reg_wr_en   <= 1'b1;
                            end
                        end else if (scl_fall && (cnt == 4'd8)) begin
                            cnt <= 4'd0;
                            if (state == DEV) begin
                                if (dev_ack) begin
                                    state      <= ACK_DEV;
                                    i2c_sda_oe <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end else begin
                                i2c_sda_oe <= 1'b1;
                                if (state == AH) begin
                                    addr_hi <= shreg;
                                    state   <= ACK_AH;
                                end else if (state == AL) begin
                                    state <= ACK_AL;
                                end else begin
                                    state <= ACK_WR;
                                end
                            end
                        end
                    end
                    ACK_DEV: begin
`ifdef I2C_SLAVE_RD_EN
                        // Read: keep ACKing; RD_LOAD ends the ACK bit.
                        if (shreg[0]) begin
                            state <= RD_LOAD;
                        end else
`endif
                        if (scl_fall) begin
                            i2c_sda_oe <= 1'b0;
                            state      <= AH;
                        end
                    end
                    ACK_AH: begin
                        if (scl_fall) begin
                            i2c_sda_oe <= 1'b0;
                            state      <= AL;
                        end
                    end
                    ACK_AL: begin
                        if (scl_fall) begin
                            i2c_sda_oe <= 1'b0;
                            reg_addr   <= {addr_hi, shreg};
                            state      <= WR;
                        end
                    end
                    ACK_WR: begin
                        if (scl_fall) begin
                            i2c_sda_oe <= 1'b0;
                            reg_addr   <= reg_addr + 16'd1;
                            state      <= WR;
                        end
                    end
`ifdef I2C_SLAVE_RD_EN
                    RD_LOAD: begin
                        // The falling edge ending the ACK also launches the MSB.
                        if (scl_fall) begin
                            shreg      <= {reg_rd_data[6:0], 1'b0};
                            i2c_sda_oe <= ~reg_rd_data[7];
                            cnt        <= 4'd1;
                            state      <= RD;
                        end
                    end
                    RD: begin
                        if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                i2c_sda_oe <= 1'b0;
                                cnt        <= 4'd0;
                                state      <= RD_MACK;
                            end else begin
                                i2c_sda_oe <= ~shreg[7];
                                shreg      <= {shreg[6:0], 1'b0};
                                cnt        <= cnt + 4'd1;
                            end
                        end
                    end
                    RD_MACK: begin
                        if (scl_rise) begin
                            if (!sda_bit) begin
                                reg_addr <= reg_addr + 16'd1;
                                state    <= RD_LOAD;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
`endif
                    WAIT_STOP: begin
                        i2c_sda_oe <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        i2c_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg16_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_reg16_slave
//  Description : Directed bench for i2c_reg16_slave acting as an I2C master
//                with a bus-level SDA model and a write-strobe logger.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_reg16_slave;

    localparam int Q = 15;   // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        sda_m;
    logic        sda_oe;
    logic        reg_wr_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wr_data;
    logic [7:0]  reg_rd_data;
    logic        busy;
    logic        sda_bus;

    int checks   = 0;
    int failures = 0;

    int          n_str = 0;
    int          n_oe  = 0;
    logic [15:0] s_addr [64];
    logic [7:0]  s_data [64];

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    always_comb begin
        case (reg_addr)
            16'h0100: reg_rd_data = 8'hA5;
            16'h0101: reg_rd_data = 8'h3C;
            default:  reg_rd_data = 8'h00;
        endcase
    end

    i2c_reg16_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2c_scl_in  (scl),
        .i2c_sda_in  (sda_bus),
        .i2c_sda_oe  (sda_oe),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    // Log every write strobe and count cycles with SDA pulled low.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            if (n_str < 64) begin
                s_addr[n_str] = reg_addr;
                s_data[n_str] = reg_wr_data;
            end
            n_str++;
        end
        if (sda_oe) n_oe++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic qwait;
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; qwait;
        scl   = 1'b1; qwait;
        sda_m = 1'b0; qwait;
        scl   = 1'b0; qwait;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; qwait;
        scl   = 1'b1; qwait;
        sda_m = 1'b1; qwait;
        qwait;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; qwait;
        scl   = 1'b1; qwait; qwait;
        scl   = 1'b0; qwait;
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; qwait;
        scl   = 1'b1; qwait;
        b     = sda_bus; qwait;
        scl   = 1'b0; qwait;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(mack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         bs;
        int         bo;

        rst_n = 1'b0;
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_oe",      32'(sda_oe),      32'h0);
        check("rst_wr_en",   32'(reg_wr_en),   32'h0);
        check("rst_addr",    32'(reg_addr),    32'h0);
        check("rst_wr_data", 32'(reg_wr_data), 32'h0);
        check("rst_busy",    32'(busy),        32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single write: 0x3039 <= 0x80
        bs = n_str;
        i2c_start;
        check("sw_busy_on", 32'(busy), 32'h1);
        write_byte(8'h60, ack); check("sw_ack_dev", 32'(ack), 32'h1);
        write_byte(8'h30, ack); check("sw_ack_ah",  32'(ack), 32'h1);
        write_byte(8'h39, ack); check("sw_ack_al",  32'(ack), 32'h1);
        write_byte(8'h80, ack); check("sw_ack_wr",  32'(ack), 32'h1);
        i2c_stop;
        check("sw_busy_off", 32'(busy),       32'h0);
        check("sw_nstrobe",  32'(n_str - bs), 32'd1);
        check("sw_addr",     32'(s_addr[bs]), 32'h3039);
        check("sw_data",     32'(s_data[bs]), 32'h80);
        check("sw_ptr",      32'(reg_addr),   32'h303A);

        // Burst write from 0x320C
        bs = n_str;
        i2c_start;
        write_byte(8'h60, ack);
        write_byte(8'h32, ack);
        write_byte(8'h0C, ack);
        write_byte(8'h03, ack);
        write_byte(8'h0C, ack);
        write_byte(8'h02, ack); check("bw_ack_last", 32'(ack), 32'h1);
        i2c_stop;
        check("bw_nstrobe", 32'(n_str - bs),     32'd3);
        check("bw_a0", 32'(s_addr[bs]),     32'h320C);
        check("bw_d0", 32'(s_data[bs]),     32'h03);
        check("bw_a1", 32'(s_addr[bs + 1]), 32'h320D);
        check("bw_d1", 32'(s_data[bs + 1]), 32'h0C);
        check("bw_a2", 32'(s_addr[bs + 2]), 32'h320E);
        check("bw_d2", 32'(s_data[bs + 2]), 32'h02);
        check("bw_ptr", 32'(reg_addr),      32'h320F);

        // Wrong device address, then a normal transaction
        bs = n_str; bo = n_oe;
        i2c_start;
        write_byte(8'h62, ack); check("wa_nack", 32'(ack), 32'h0);
        write_byte(8'h00, ack);
        write_byte(8'h77, ack);
        i2c_stop;
        check("wa_no_oe",     32'(n_oe - bo),  32'd0);
        check("wa_no_strobe", 32'(n_str - bs), 32'd0);
        bs = n_str;
        i2c_start;
        write_byte(8'h60, ack); check("wa_next_ack", 32'(ack), 32'h1);
        write_byte(8'h12, ack);
        write_byte(8'h34, ack);
        write_byte(8'h56, ack);
        i2c_stop;
        check("wa_next_n",    32'(n_str - bs), 32'd1);
        check("wa_next_addr", 32'(s_addr[bs]), 32'h1234);
        check("wa_next_data", 32'(s_data[bs]), 32'h56);

`ifdef I2C_SLAVE_RD_EN
        // Pointer write, repeated START, two-byte read
        i2c_start;
        write_byte(8'h60, ack);
        write_byte(8'h01, ack);
        write_byte(8'h00, ack);
        i2c_start;
        write_byte(8'h61, ack); check("rd_ack_dev", 32'(ack), 32'h1);
        read_byte(1'b0, rd);    check("rd_byte0",   32'(rd),  32'hA5);
        read_byte(1'b1, rd);    check("rd_byte1",   32'(rd),  32'h3C);
        check("rd_ptr", 32'(reg_addr), 32'h0101);
        i2c_stop;
        check("rd_busy_off", 32'(busy), 32'h0);
`else
        // Read request without the read path is refused
        i2c_start;
        write_byte(8'h60, ack);
        write_byte(8'h01, ack);
        write_byte(8'h00, ack);
        i2c_start;
        write_byte(8'h61, ack); check("rd_nack", 32'(ack), 32'h0);
        i2c_stop;
        check("rd_ptr", 32'(reg_addr), 32'h0100);
`endif

        // Address-only write then STOP in the middle of a data byte
        bs = n_str;
        i2c_start;
        write_byte(8'h60, ack);
        write_byte(8'h00, ack);
        write_byte(8'h10, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop;
        check("ps_no_strobe", 32'(n_str - bs), 32'd0);
        check("ps_busy",      32'(busy),       32'h0);
        check("ps_oe",        32'(sda_oe),     32'h0);
        check("ps_ptr",       32'(reg_addr),   32'h0010);

        // Pointer wrap
        bs = n_str;
        i2c_start;
        write_byte(8'h60, ack);
        write_byte(8'hFF, ack);
        write_byte(8'hFF, ack);
        write_byte(8'hAA, ack);
        write_byte(8'h55, ack);
        i2c_stop;
        check("wr_n",  32'(n_str - bs),     32'd2);
        check("wr_a0", 32'(s_addr[bs]),     32'hFFFF);
        check("wr_d0", 32'(s_data[bs]),     32'hAA);
        check("wr_a1", 32'(s_addr[bs + 1]), 32'h0000);
        check("wr_d1", 32'(s_data[bs + 1]), 32'h55);
        check("wr_ptr", 32'(reg_addr),      32'h0001);

        // General call is NACKed
        bo = n_oe;
        i2c_start;
        write_byte(8'h00, ack); check("gc_nack", 32'(ack), 32'h0);
        i2c_stop;
        check("gc_no_oe", 32'(n_oe - bo), 32'd0);

        // Reset during the device ACK bit
        i2c_start;
        for (int i = 7; i >= 0; i--) send_bit(((8'h60 >> i) & 8'h01) != 8'h00);
        sda_m = 1'b1; qwait;
        scl   = 1'b1; qwait;
        check("ra_oe_ack", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("ra_oe",      32'(sda_oe),      32'h0);
        check("ra_busy",    32'(busy),        32'h0);
        check("ra_addr",    32'(reg_addr),    32'h0);
        check("ra_wr_data", 32'(reg_wr_data), 32'h0);
        check("ra_wr_en",   32'(reg_wr_en),   32'h0);
        rst_n = 1'b1;
        bs = n_str; bo = n_oe;
        qwait;
        scl = 1'b0; qwait;
        write_byte(8'h12, ack); check("ra_ignored_ack", 32'(ack), 32'h0);
        write_byte(8'h34, ack);
        check("ra_no_oe",     32'(n_oe - bo),  32'd0);
        check("ra_no_strobe", 32'(n_str - bs), 32'd0);
        check("ra_busy_idle", 32'(busy),       32'h0);
        i2c_stop;
        bs = n_str;
        i2c_start;
        write_byte(8'h60, ack); check("ra_fresh_ack", 32'(ack), 32'h1);
        write_byte(8'hAB, ack);
        write_byte(8'hCD, ack);
        write_byte(8'h11, ack);
        i2c_stop;
        check("ra_fresh_n",    32'(n_str - bs), 32'd1);
        check("ra_fresh_addr", 32'(s_addr[bs]), 32'hABCD);
        check("ra_fresh_data", 32'(s_data[bs]), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
